// File: rtl/sim_exit_monitor.sv
// rtl/sim_exit_monitor.sv - multi-channel tohost exit monitor with cycle watchdog
// Latches the first exit per hart and resolves one registered pass/fail/timeout verdict.
module sim_exit_monitor #(
  parameter int NumChannels = 4,
  parameter int TohostWidth = 32,
  parameter int CycleWidth  = 64,
  parameter int ExitMode    = 0,
  localparam int ChW        = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int CodeW      = TohostWidth - 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic [NumChannels-1:0]             tohost_valid_i,
  input  logic [NumChannels*TohostWidth-1:0] tohost_i,
  input  logic [CycleWidth-1:0]              max_cycles_i,
  output logic [CycleWidth-1:0]              cycles_o,
  output logic                               done_o,
  output logic                               pass_o,
  output logic                               fail_o,
  output logic                               timeout_o,
  output logic [CodeW-1:0]                   exit_code_o,
  output logic [ChW-1:0]                     first_ch_o,
  output logic [NumChannels-1:0]             ch_done_o,
  output logic [NumChannels-1:0]             ch_fail_o
);

  typedef enum logic {ST_RUN, ST_DONE} state_e;

  state_e                 r_state, w_state_nxt;
  logic [CycleWidth-1:0]  r_cycles, w_cycles_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_pass, w_pass_nxt;
  logic                   r_fail, w_fail_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic [CodeW-1:0]       r_exit_code, w_exit_code_nxt;
  logic [ChW-1:0]         r_first_ch, w_first_ch_nxt;
  logic [NumChannels-1:0] r_ch_done, w_ch_done_nxt;
  logic [NumChannels-1:0] r_ch_fail, w_ch_fail_nxt;
  logic [CodeW-1:0]       r_code [NumChannels];
  logic [CodeW-1:0]       w_code_nxt [NumChannels];

  logic [NumChannels-1:0] w_exit;
  logic [ChW-1:0]         w_new_ch, w_fail_ch;
  logic [CodeW-1:0]       w_new_code, w_fail_code;
  logic                   w_any_fail, w_complete, w_timeout_hit;

  always_comb begin
    w_state_nxt     = r_state;
    w_cycles_nxt    = r_cycles;
    w_done_nxt      = r_done;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_timeout_nxt   = r_timeout;
    w_exit_code_nxt = r_exit_code;
    w_first_ch_nxt  = r_first_ch;
    w_ch_done_nxt   = r_ch_done;
    w_ch_fail_nxt   = r_ch_fail;
    w_code_nxt      = r_code;
    w_exit          = '0;
    w_new_ch        = '0;
    w_new_code      = '0;
    w_fail_ch       = '0;
    w_fail_code     = '0;
    w_any_fail      = 1'b0;
    w_complete      = 1'b0;
    w_timeout_hit   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_cycles != '1) w_cycles_nxt = r_cycles + CycleWidth'(1);
        // Descending scan so the lowest index is the last (winning) assignment.
        for (int c = NumChannels - 1; c >= 0; c--) begin
          if (tohost_valid_i[c] && tohost_i[c*TohostWidth] && !r_ch_done[c]) begin
            w_exit[c]        = 1'b1;
            w_ch_done_nxt[c] = 1'b1;
            w_code_nxt[c]    = tohost_i[c*TohostWidth+1 +: CodeW];
            w_ch_fail_nxt[c] = (w_code_nxt[c] != '0);
            w_new_ch         = ChW'(c);
            w_new_code       = w_code_nxt[c];
          end
          if (w_ch_fail_nxt[c]) begin
            w_any_fail  = 1'b1;
            w_fail_ch   = ChW'(c);
            w_fail_code = w_code_nxt[c];
          end
        end
        w_timeout_hit = (max_cycles_i != '0) && (w_cycles_nxt >= max_cycles_i);
        w_complete    = (ExitMode == 0) ? (|w_exit) : (&w_ch_done_nxt);
        if (w_complete) begin
          w_state_nxt   = ST_DONE;
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b0;
          if (ExitMode == 0) begin
            w_exit_code_nxt = w_new_code;
            w_first_ch_nxt  = w_new_ch;
            w_fail_nxt      = (w_new_code != '0);
          end else if (w_any_fail) begin
            w_exit_code_nxt = w_fail_code;
            w_first_ch_nxt  = w_fail_ch;
            w_fail_nxt      = 1'b1;
          end else begin
            w_exit_code_nxt = '0;
            w_first_ch_nxt  = w_new_ch;
            w_fail_nxt      = 1'b0;
          end
          w_pass_nxt = !w_fail_nxt;
        end else if (w_timeout_hit) begin
          w_state_nxt     = ST_DONE;
          w_done_nxt      = 1'b1;
          w_timeout_nxt   = 1'b1;
          w_fail_nxt      = 1'b1;
          w_pass_nxt      = 1'b0;
          w_exit_code_nxt = '0;
          w_first_ch_nxt  = '0;
        end
      end
      ST_DONE: begin
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= ST_RUN;
      r_cycles    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_exit_code <= '0;
      r_first_ch  <= '0;
      r_ch_done   <= '0;
      r_ch_fail   <= '0;
      for (int c = 0; c < NumChannels; c++) r_code[c] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cycles    <= w_cycles_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_timeout   <= w_timeout_nxt;
      r_exit_code <= w_exit_code_nxt;
      r_first_ch  <= w_first_ch_nxt;
      r_ch_done   <= w_ch_done_nxt;
      r_ch_fail   <= w_ch_fail_nxt;
      for (int c = 0; c < NumChannels; c++) r_code[c] <= w_code_nxt[c];
    end
  end

  assign cycles_o    = r_cycles;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;
  assign exit_code_o = r_exit_code;
  assign first_ch_o  = r_first_ch;
  assign ch_done_o   = r_ch_done;
  assign ch_fail_o   = r_ch_fail;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb/tb_sim_exit_monitor.sv - directed bench for sim_exit_monitor
// Drives ANY-mode, ALL-mode and 4-bit-counter instances with shared stimulus.
module tb_sim_exit_monitor;

  logic         clk;
  logic         rst, clr, s_rst;
  logic [3:0]   vld;
  logic [127:0] th;
  logic [63:0]  maxc;
  logic [3:0]   s_maxc;
  logic [3:0]   s_vld;
  logic [127:0] s_th;

  logic [63:0] a_cyc, b_cyc;
  logic        a_done, a_pass, a_fail, a_to, b_done, b_pass, b_fail, b_to;
  logic [30:0] a_code, b_code, s_code;
  logic [1:0]  a_first, b_first, s_first;
  logic [3:0]  a_chd, a_chf, b_chd, b_chf, s_chd, s_chf;
  logic [3:0]  s_cyc;
  logic        s_done, s_pass, s_fail, s_to;

  int tests = 0;
  int failed = 0;

  sim_exit_monitor #(.NumChannels(4), .TohostWidth(32), .CycleWidth(64), .ExitMode(0)) u_any (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .tohost_valid_i(vld), .tohost_i(th),
    .max_cycles_i(maxc), .cycles_o(a_cyc), .done_o(a_done), .pass_o(a_pass),
    .fail_o(a_fail), .timeout_o(a_to), .exit_code_o(a_code), .first_ch_o(a_first),
    .ch_done_o(a_chd), .ch_fail_o(a_chf));

  sim_exit_monitor #(.NumChannels(4), .TohostWidth(32), .CycleWidth(64), .ExitMode(1)) u_all (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .tohost_valid_i(vld), .tohost_i(th),
    .max_cycles_i(maxc), .cycles_o(b_cyc), .done_o(b_done), .pass_o(b_pass),
    .fail_o(b_fail), .timeout_o(b_to), .exit_code_o(b_code), .first_ch_o(b_first),
    .ch_done_o(b_chd), .ch_fail_o(b_chf));

  sim_exit_monitor #(.NumChannels(4), .TohostWidth(32), .CycleWidth(4), .ExitMode(0)) u_sat (
    .clk_i(clk), .rst_i(s_rst), .clear_i(1'b0), .tohost_valid_i(s_vld), .tohost_i(s_th),
    .max_cycles_i(s_maxc), .cycles_o(s_cyc), .done_o(s_done), .pass_o(s_pass),
    .fail_o(s_fail), .timeout_o(s_to), .exit_code_o(s_code), .first_ch_o(s_first),
    .ch_done_o(s_chd), .ch_fail_o(s_chf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int ch, input logic [31:0] val);
    vld[ch] = 1'b1;
    th[ch*32 +: 32] = val;
  endtask

  task automatic go();
    step(1);
    vld = '0;
    th  = '0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; s_rst = 1'b1;
    vld = '0; th = '0; maxc = '0; s_maxc = '0; s_vld = '0; s_th = '0;
    step(2);
    s_rst = 1'b0;
    chk("rst_cycles", a_cyc, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_chd", a_chd, 0);
    chk("rst_all_done", b_done, 0);

    // ANY: ch2 exits with code 0 while cycles_o reads 10
    rst = 1'b0;
    step(10);
    chk("any_cyc10", a_cyc, 10);
    put(2, 32'h1); go();
    chk("any_done", a_done, 1);
    chk("any_pass", a_pass, 1);
    chk("any_fail", a_fail, 0);
    chk("any_code", a_code, 0);
    chk("any_first", a_first, 2);
    chk("any_chd", a_chd, 4'b0100);
    chk("any_cyc11", a_cyc, 11);
    put(0, 32'h1); go();
    step(3);
    chk("any_frozen_cyc", a_cyc, 11);
    chk("any_frozen_chd", a_chd, 4'b0100);

    // Re-arm with clear_i from DONE
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_done", a_done, 0);
    chk("clr_pass", a_pass, 0);
    chk("clr_cyc", a_cyc, 0);
    chk("clr_chd", a_chd, 0);
    step(1);
    chk("clr_resume", a_cyc, 1);

    // ANY: simultaneous exits, lowest index wins
    put(1, 32'h7); put(3, 32'h1); go();
    chk("sim_fail", a_fail, 1);
    chk("sim_pass", a_pass, 0);
    chk("sim_code", a_code, 3);
    chk("sim_first", a_first, 1);
    chk("sim_chd", a_chd, 4'b1010);
    chk("sim_chf", a_chf, 4'b0010);

    // ALL mode sequence
    pulse_rst();
    step(3);
    put(0, 32'h2); go();
    chk("all_syscall_ignored", b_chd, 4'b0000);
    put(0, 32'h1); go();
    chk("all_ch0", b_chd, 4'b0001);
    step(2);
    put(1, 32'h5); go();
    chk("all_ch1_chf", b_chf, 4'b0010);
    put(2, 32'h1); go();
    step(2);
    put(0, 32'hB); go();
    chk("all_ch0_second_chf", b_chf, 4'b0010);
    chk("all_not_done", b_done, 0);
    chk("all_chd_0111", b_chd, 4'b0111);
    step(7);
    put(3, 32'h1); go();
    chk("all_done", b_done, 1);
    chk("all_fail", b_fail, 1);
    chk("all_pass", b_pass, 0);
    chk("all_code", b_code, 2);
    chk("all_first", b_first, 1);
    chk("all_chf", b_chf, 4'b0010);

    // ALL: reset mid-run discards ch1's latch
    pulse_rst();
    put(1, 32'h1); go();
    chk("mid_ch1", b_chd, 4'b0010);
    pulse_rst();
    chk("mid_rst_chd", b_chd, 0);
    put(0, 32'h1); put(2, 32'h1); put(3, 32'h1); go();
    chk("mid_not_done", b_done, 0);
    chk("mid_chd", b_chd, 4'b1101);
    put(1, 32'h1); go();
    chk("mid_done", b_done, 1);
    chk("mid_pass", b_pass, 1);
    chk("mid_code", b_code, 0);
    chk("mid_first_last", b_first, 1);

    // Watchdog at 100 with no exits
    maxc = 64'd100;
    pulse_rst();
    step(99);
    chk("wd_99_done", a_done, 0);
    step(1);
    chk("wd_cyc", a_cyc, 100);
    chk("wd_done", a_done, 1);
    chk("wd_to", a_to, 1);
    chk("wd_fail", a_fail, 1);
    chk("wd_pass", a_pass, 0);
    chk("wd_first", a_first, 0);
    step(1);
    chk("wd_frozen", a_cyc, 100);

    // Exit on the same edge as the watchdog wins
    pulse_rst();
    step(99);
    put(3, 32'h1); go();
    chk("wdx_cyc", a_cyc, 100);
    chk("wdx_done", a_done, 1);
    chk("wdx_to", a_to, 0);
    chk("wdx_pass", a_pass, 1);
    chk("wdx_first", a_first, 3);

    // Lowering the limit below the count trips on the next edge
    maxc = '0;
    pulse_rst();
    step(20);
    chk("low_not_done", a_done, 0);
    maxc = 64'd5;
    step(1);
    chk("low_done", a_done, 1);
    chk("low_to", a_to, 1);
    chk("low_cyc", a_cyc, 21);

    // Unlimited watchdog for 10000 cycles
    maxc = '0;
    pulse_rst();
    step(10000);
    chk("unl_done", a_done, 0);
    chk("unl_cyc", a_cyc, 10000);

    // 4-bit counter saturates
    chk("sat_cyc", s_cyc, 15);
    chk("sat_done", s_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sim_exit_monitor.md
# sim_exit_monitor

Synthesizable, parametrised simulation-exit monitor for the test harness. It watches the tohost exit words of up to NumChannels harts and counts cycles. It enforces an optional max-cycle watchdog and resolves a single pass/fail/timeout verdict under either an any-exit or all-exit policy. It replaces ad-hoc single-channel testbench polling and works identically in simulation and FPGA builds.

## Interface
- NumChannels, 4: number of monitored harts/tohost channels (>=1)
- TohostWidth, 32: width of each tohost word
- CycleWidth, 64: width of the cycle counter and watchdog limit
- ExitMode, 0: 0 = finish on first exiting channel (ANY); 1 = finish when every channel has exited (ALL)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  re-arm: same effect as rst_i, sampled on clk_i
- tohost_valid_i  in  NumChannels  per-channel tohost write strobe
- tohost_i  in  NumChannels*TohostWidth  per-channel tohost data; channel c occupies bits [c*TohostWidth +: TohostWidth]
- max_cycles_i  in  CycleWidth  watchdog limit; 0 = unlimited
- cycles_o  out  CycleWidth  cycles elapsed since reset/clear
- done_o  out  1  verdict valid (sticky)
- pass_o  out  1  done with all relevant codes zero and no timeout
- fail_o  out  1  done with nonzero code or timeout
- timeout_o  out  1  done caused by watchdog
- exit_code_o  out  TohostWidth-1  resolved exit code (tohost >> 1)
- first_ch_o  out  max(1,$clog2(NumChannels))  channel that determined the verdict
- ch_done_o  out  NumChannels  per-channel exited flags
- ch_fail_o  out  NumChannels  per-channel nonzero-code flags

## Operation
- States: RUN and DONE. Reset and clear_i enter RUN. All outputs reset to 0, cycles_o included.
- Exit detection: tohost_valid_i[c]=1 with tohost bit0=1 is an exit on channel c, with code = tohost[TohostWidth-1:1]. A write with bit0=0 is a syscall/proxy write and is ignored.
- Only the first exit of a channel is latched. Later writes to a latched channel are ignored. In RUN, the latch sets ch_done_o[c], sets ch_fail_o[c] = (code != 0), and stores the code per channel.
- ANY mode: the first exit moves RUN to DONE. If several channels exit in the same cycle, the lowest index wins. That channel's code drives exit_code_o and its index drives first_ch_o. The other simultaneous exits still set their ch_done_o/ch_fail_o bits.
- ALL mode: the block moves to DONE once every ch_done_o bit is set. If any channel failed, exit_code_o and first_ch_o come from the lowest-index failing channel. Otherwise exit_code_o=0 and first_ch_o is the last channel to exit, lowest index on a tie.
- Watchdog: in RUN, cycles_o increments by 1 each cycle and saturates at all-ones. If max_cycles_i != 0 and the next count is >= max_cycles_i, the block moves to DONE with timeout_o=1, fail_o=1, exit_code_o=0 and first_ch_o=0. Lowering max_cycles_i below the current count triggers a timeout on the next edge.
- Simultaneous events: if a completing exit and a timeout occur on the same edge, the exit wins and timeout_o stays 0.
- DONE: all outputs are frozen, cycles_o stops counting, and tohost writes are ignored. Only rst_i or clear_i leave DONE.
- pass_o = done_o & ~fail_o. pass_o and fail_o are never both 1.
- rst_i or clear_i asserted mid-run discards partially latched channel state. rst_i has priority over clear_i, and both have priority over exit and timeout events on the same edge.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- An exit strobe sampled at edge k shows up on ch_done_o and ch_fail_o after edge k.
- The resulting done_o, pass_o, fail_o, exit_code_o and first_ch_o appear in the same cycle as ch_done_o (1-cycle latency).
- Timeout: done_o and timeout_o rise in the same cycle that cycles_o first equals max_cycles_i.
- After rst_i or clear_i is released, the first counted cycle makes cycles_o=1 on the following edge.
- tohost_i is sampled only when the matching tohost_valid_i bit is high.

## Test plan
- ANY, NumChannels=4: ch2 writes 0x1 at cycle 10 -> done_o=1, pass_o=1, exit_code_o=0, first_ch_o=2, ch_done_o=4'b0100 from cycle 11; cycles_o frozen at 11.
- ANY, simultaneous exits: ch1 writes 0x7 and ch3 writes 0x1 on the same edge -> fail_o=1, exit_code_o=3, first_ch_o=1, ch_done_o=4'b1010, ch_fail_o=4'b0010.
- ALL: ch0 0x1 @5, ch1 0x5 @8, ch2 0x1 @9, ch3 0x1 @20; ch0 writes 0xB again @12 -> done_o only after the cycle-20 edge, fail_o=1, exit_code_o=2, first_ch_o=1, ch_fail_o=4'b0010, ch0's second write ignored. Also ch0 writes 0x2 (bit0=0) -> no effect.
- Watchdog: max_cycles_i=100 with no exits -> timeout_o=fail_o=done_o=1 exactly when cycles_o=100. Repeat with an exit strobe on the edge that reaches 100 -> exit verdict wins, timeout_o=0. With max_cycles_i=0 and no exits for 10000 cycles -> done_o stays 0.
- Re-arm: clear_i for one cycle in DONE -> all outputs 0 next cycle, counting resumes. Mid-run, with ch1 latched in ALL mode, rst_i -> ch_done_o=0 and the run must see every channel exit again.
- Saturation: CycleWidth=4, max_cycles_i=0 -> cycles_o holds 15 and does not wrap.
